mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-ported `memory2c` between the fetch stage (instruction reads) and the memory stage (data loads/stores), so one physical memory can serve both. Each granted access is held for a programmable number of cycles, which models a multi-cycle memory. The requesting stage receives a stall while its access is pending and a one-cycle done pulse with registered read data when it completes. On halt, the arbiter drains the in-flight access, issues the memory dump and then locks out further accesses.

## Interface
Parameters:
- `LATENCY`, default 2: cycles per memory access; legal range 1..15.
- `STARVE_MAX`, default 3: consecutive fetch losses after which fetch wins the next arbitration; legal range 1..3.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch read request, level; held until `if_done`.
- `if_addr` in 16: fetch address; stable while `if_req` is high.
- `if_rdata` out 16: registered instruction word; valid when `if_done` is high; held otherwise.
- `if_done` out 1: one-cycle completion pulse for fetch.
- `if_stall` out 1: `if_req & ~if_done`.
- `d_req` in 1: data request, level; held until `d_done`.
- `d_wr` in 1: 1 = store, 0 = load; stable with `d_req`.
- `d_addr` in 16: data address.
- `d_wdata` in 16: store data.
- `d_rdata` out 16: registered load data; valid when `d_done` is high; held otherwise.
- `d_done` out 1: one-cycle completion pulse for data.
- `d_stall` out 1: `d_req & ~d_done`.
- `halt` in 1: program halt request; a sticky event, latched internally.
- `mem_enable` out 1: to `memory2c`.
- `mem_wr` out 1: to `memory2c`.
- `mem_addr` out 16: to `memory2c`.
- `mem_data_in` out 16: to `memory2c`.
- `mem_createdump` out 1: to `memory2c`.
- `mem_data_out` in 16: from `memory2c`; combinational read data.

## Operation
- States:
  - IDLE
  - IF_ACC
  - D_ACC
  - DUMP
  - HALTED
- Reset: state IDLE; access counter 0; starve counter 0; halt latch 0. All outputs are 0, including both `rdata` registers.
- `halt` is latched on any cycle it is high. The latch is cleared only by `rst`.
- Arbitration happens in IDLE only, evaluated every cycle, in this priority order:
  1. If the halt latch is set, go to DUMP.
  2. If a port's done pulse is high this cycle, that port is ineligible this cycle, so a still-held request is not re-granted.
  3. If both ports are eligible: D_ACC, unless the starve counter equals `STARVE_MAX`, in which case IF_ACC.
  4. Otherwise, grant the single eligible requester.
  5. With no eligible requester, stay in IDLE.
- Starve counter (2 bits, saturating):
  - increments when fetch loses an arbitration while eligible;
  - clears when IF_ACC is granted.
- In IF_ACC or D_ACC:
  - `mem_enable` = 1.
  - `mem_addr` = address of the granted port.
  - `mem_data_in` = `d_wdata` (0 in IF_ACC).
  - The access counter counts 1..`LATENCY`.
- `mem_wr` = `d_wr` only on the final cycle of D_ACC (counter == `LATENCY`); 0 at all other times. Each store therefore writes exactly once.
- On the final access cycle:
  - `mem_data_out` is captured into the granted port's `rdata` register (loads and fetches only; stores leave `d_rdata` unchanged).
  - The state goes to IDLE and the port's done register is set for the next cycle.
- The halt latch never aborts an in-flight access; it takes effect at the next IDLE.
- DUMP lasts one cycle: `mem_createdump` = 1, `mem_enable` = 0, then the state goes to HALTED.
- HALTED:
  - all `mem_*` outputs are 0;
  - requests are ignored, with no done pulses;
  - stalls follow their formulas (stay high while a request is held);
  - the state is left only by `rst`.
- Reset mid-access aborts the access. A store that has not reached its final-cycle edge is not written.

## Timing
- A request first seen in IDLE at cycle N:
  - `mem_enable` is high for cycles N+1 .. N+`LATENCY`;
  - `rdata` and done are valid at cycle N+1+`LATENCY`.
- Total latency, request to done: `LATENCY`+1 cycles.
- Back-to-back: the done cycle is an IDLE cycle, so a waiting other port is granted then. Its access starts the following cycle, giving one idle memory cycle between accesses.
- Both requests arriving in the same cycle: the data access completes first; fetch is granted at that data access's done cycle.
- A request asserted during the other port's access waits; its stall stays high throughout.
- `halt` asserted during an access:
  - DUMP occurs on the cycle after that access's done cycle;
  - `mem_createdump` pulses exactly once.

## Test plan
- Single fetch, `LATENCY`=2: `if_req`=1 with `if_addr`=0x0010 at cycle 0, where memory holds 0x1234 -> `mem_enable` is high at cycles 1–2; `if_done`=1 and `if_rdata`=0x1234 at cycle 3; `if_stall` is high at cycles 0–2.
- Store then load: store 0xBEEF to 0x0040 -> `mem_wr` is high for only 1 cycle; a later load of 0x0040 returns `d_rdata`=0xBEEF.
- Contention and starvation, `STARVE_MAX`=3: `if_req` held while `d_req` is re-asserted after every `d_done` -> grants are D, D, D, IF; the starve counter returns to 0 after the IF grant.
- Simultaneous requests at cycle 0 -> `d_done` at cycle 3 and `if_done` at cycle 6; neither done pulse lasts more than 1 cycle.
- `halt` pulsed at cycle 1 during a fetch -> `if_done` at cycle 3, `mem_createdump`=1 at cycle 4 only; a later `d_req` gets no `d_done` and `d_stall` stays 1.
- `rst` asserted mid-store (before the final cycle) -> all outputs are 0 immediately and the memory location is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access,
// with programmable access latency, fetch anti-starvation and a halt/dump sequence.
module mem_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    input  logic        halt,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_createdump,
    input  logic [15:0] mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_ACC,
        S_D_ACC,
        S_DUMP,
        S_HALTED
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);
    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [1:0]  r_starve;
    logic        r_halt;
    logic        r_if_done;
    logic        r_d_done;
    logic [15:0] r_if_rdata;
    logic [15:0] r_d_rdata;

    logic w_if_elig;
    logic w_d_elig;
    logic w_last;
    logic w_grant_if;
    logic w_grant_d;

    // A port whose done pulse is high is still holding its request; it must not be re-granted.
    assign w_if_elig  = if_req & ~r_if_done;
    assign w_d_elig   = d_req & ~r_d_done;
    assign w_last     = (r_cnt == LAT_CNT);
    assign w_grant_if = (r_state == S_IDLE) && (w_next == S_IF_ACC);
    assign w_grant_d  = (r_state == S_IDLE) && (w_next == S_D_ACC);

    // NOTE: every clocked process uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_halt) begin
                    w_next = S_DUMP;
                end else if (w_if_elig && w_d_elig) begin
                    w_next = (r_starve == STARVE_LIM) ? S_IF_ACC : S_D_ACC;
                end else if (w_if_elig) begin
                    w_next = S_IF_ACC;
                end else if (w_d_elig) begin
                    w_next = S_D_ACC;
                end
            end
            S_IF_ACC, S_D_ACC: begin
                if (w_last) w_next = S_IDLE;
            end
            S_DUMP:   w_next = S_HALTED;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = 16'h0000;
        mem_data_in    = 16'h0000;
        mem_createdump = 1'b0;
        case (r_state)
            S_IF_ACC: begin
                mem_enable = 1'b1;
                mem_addr   = if_addr;
            end
            S_D_ACC: begin
                mem_enable  = 1'b1;
                mem_addr    = d_addr;
                mem_data_in = d_wdata;
                // Store strobe only on the final cycle so each store writes exactly once.
                mem_wr      = d_wr & w_last;
            end
            S_DUMP:  mem_createdump = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_starve   <= 2'd0;
            r_halt     <= 1'b0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_if_rdata <= 16'h0000;
            r_d_rdata  <= 16'h0000;
        end else begin
            r_halt    <= r_halt | halt;
            r_if_done <= (r_state == S_IF_ACC) && w_last;
            r_d_done  <= (r_state == S_D_ACC) && w_last;

            if (w_grant_if || w_grant_d) begin
                r_cnt <= 4'd1;
            end else if ((r_state == S_IF_ACC || r_state == S_D_ACC) && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end

            if (w_grant_if) begin
                r_starve <= 2'd0;
            end else if (w_grant_d && w_if_elig && r_starve != 2'd3) begin
                r_starve <= r_starve + 2'd1;
            end

            if (r_state == S_IF_ACC && w_last) begin
                r_if_rdata <= mem_data_out;
            end
            if (r_state == S_D_ACC && w_last && !d_wr) begin
                r_d_rdata <= mem_data_out;
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign if_done  = r_if_done;
    assign if_stall = if_req & ~r_if_done;
    assign d_rdata  = r_d_rdata;
    assign d_done   = r_d_done;
    assign d_stall  = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// cycle-timeline reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        halt = 1'b0;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_createdump;
    logic [15:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall), .halt(halt),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_createdump(mem_createdump), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural memory2c: combinational read, write on the clock edge.
    logic [15:0] ram [0:65535];
    logic        bd_init = 1'b0;
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'h0000;
    logic [15:0] bd_data = 16'h0000;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    assign mem_data_out = ram[mem_addr];

    always @(posedge clk) begin
        if (bd_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(16'(i));
        end else if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_enable && mem_wr) begin
            ram[mem_addr] <= mem_data_in;
        end
    end

    logic [70:0] all_out;
    assign all_out = {if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
                      mem_enable, mem_wr, mem_addr, mem_data_in, mem_createdump};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [15:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        step();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; halt = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Runs one data request; returns the cycle (from request) of d_done, or -1 on timeout.
    task automatic run_d(input logic wr, input logic [15:0] a, input logic [15:0] v,
                         output int done_c, output int wrs);
        d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = v;
        done_c = -1; wrs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_wr) wrs++;
            if (d_done) begin
                done_c = c;
                break;
            end
            step();
        end
        step();
        d_req = 1'b0; d_wr = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        bd_init = 1'b1;
        step();
        bd_init = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        bd_write(16'h0010, 16'h1234);
        if_req = 1'b1; if_addr = 16'h0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (mem_enable !== (c == 1 || c == 2)) begin
                errors++;
                $display("FAIL fetch_mem_enable c%0d: got %b", c, mem_enable);
            end
            checks++;
            if (if_stall !== (c <= 2)) begin
                errors++;
                $display("FAIL fetch_stall c%0d: got %b", c, if_stall);
            end
            checks++;
            if (if_done !== (c == 3)) begin
                errors++;
                $display("FAIL fetch_done c%0d: got %b", c, if_done);
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 16'h1234) begin
                    errors++;
                    $display("FAIL fetch_rdata: got %h expected 1234", if_rdata);
                end
            end
            step();
            if (c == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_store_load();
        int dc, wrs;
        do_reset();
        run_d(1'b1, 16'h0040, 16'hBEEF, dc, wrs);
        checks++;
        if (dc != 3) begin
            errors++;
            $display("FAIL store_done_cycle: got %0d expected 3", dc);
        end
        checks++;
        if (wrs != 1) begin
            errors++;
            $display("FAIL store_wr_cycles: got %0d expected 1", wrs);
        end
        checks++;
        if (ram[16'h0040] !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_mem: got %h expected beef", ram[16'h0040]);
        end
        step();
        run_d(1'b0, 16'h0040, 16'h0000, dc, wrs);
        checks++;
        if (d_rdata !== 16'hBEEF || dc != 3 || wrs != 0) begin
            errors++;
            $display("FAIL load_back: got %h cyc %0d wrs %0d expected beef cyc 3 wrs 0", d_rdata, dc, wrs);
        end
    endtask

    task automatic test_simultaneous();
        int if_c = -1, d_c = -1, if_n = 0, d_n = 0;
        do_reset();
        bd_write(16'h0020, 16'h1111);
        bd_write(16'h0030, 16'h2222);
        if_req = 1'b1; if_addr = 16'h0020;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
        for (int c = 0; c < 10; c++) begin
            logic sif, sd;
            @(negedge clk);
            sif = if_done; sd = d_done;
            if (sif) begin if_n++; if (if_c < 0) if_c = c; end
            if (sd) begin d_n++; if (d_c < 0) d_c = c; end
            step();
            if (sif) if_req = 1'b0;
            if (sd) d_req = 1'b0;
        end
        checks++;
        if (d_c != 3 || d_n != 1) begin
            errors++;
            $display("FAIL simul_d_done: cycle %0d pulses %0d expected cycle 3 pulses 1", d_c, d_n);
        end
        checks++;
        if (if_c != 6 || if_n != 1) begin
            errors++;
            $display("FAIL simul_if_done: cycle %0d pulses %0d expected cycle 6 pulses 1", if_c, if_n);
        end
        checks++;
        if (if_rdata !== 16'h1111 || d_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL simul_rdata: got if %h d %h expected 1111 2222", if_rdata, d_rdata);
        end
    endtask

    // Both ports request together; fetch withdraws once it has visibly lost.
    task automatic starve_round(output logic got_d, output logic timed_out);
        if_req = 1'b1; if_addr = 16'h0050;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0060;
        @(negedge clk);
        step();
        @(negedge clk);
        got_d = (mem_addr == 16'h0060);
        step();
        if (got_d) if_req = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 20; c++) begin
            logic sif, sd;
            @(negedge clk);
            sif = if_done; sd = d_done;
            step();
            if (sif) if_req = 1'b0;
            if (sd) d_req = 1'b0;
            if (!if_req && !d_req) begin
                timed_out = 1'b0;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic got_d, to;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            starve_round(got_d, to);
            checks++;
            if (got_d !== (r != 3) || to) begin
                errors++;
                $display("FAIL starve_round%0d: data_won %b timeout %b expected data_won %b", r, got_d, to, r != 3);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        bd_write(16'h0010, 16'h4321);
        if_req = 1'b1; if_addr = 16'h0010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (if_done !== (c == 3) || mem_createdump !== (c == 4)) begin
                errors++;
                $display("FAIL halt_seq c%0d: done %b dump %b", c, if_done, mem_createdump);
            end
            step();
            if (c == 0) halt = 1'b1;
            if (c == 1) halt = 1'b0;
            if (c == 3) if_req = 1'b0;
        end
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (d_done !== 1'b0 || d_stall !== 1'b1 || mem_enable !== 1'b0 || mem_createdump !== 1'b0) begin
                errors++;
                $display("FAIL halted_c%0d: done %b stall %b en %b dump %b", c, d_done, d_stall, mem_enable, mem_createdump);
            end
            step();
        end
        d_req = 1'b0;
        checks++;
        if (ram[16'h0010] !== 16'h4321) begin
            errors++;
            $display("FAIL halted_mem: got %h expected 4321", ram[16'h0010]);
        end
    endtask

    task automatic test_reset_mid_store();
        int dc, wrs;
        do_reset();
        bd_write(16'h0080, 16'h1111);
        run_d(1'b0, 16'h0080, 16'h0000, dc, wrs);
        checks++;
        if (d_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL pre_reset_load: got %h expected 1111", d_rdata);
        end
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0080; d_wdata = 16'hCAFE;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (mem_enable !== 1'b1 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL mid_store_state: en %b wr %b expected 1 0", mem_enable, mem_wr);
        end
        #1;
        rst = 1'b1; d_req = 1'b0; d_wr = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_store_outputs: got %h expected 0", all_out);
        end
        step();
        step();
        rst = 1'b0;
        checks++;
        if (ram[16'h0080] !== 16'h1111) begin
            errors++;
            $display("FAIL reset_mid_store_mem: got %h expected 1111", ram[16'h0080]);
        end
    endtask

    // Reference model: each grant occupies a time window; arbitration only when the window has passed.
    task automatic test_random();
        logic [15:0] ref_mem [0:15];
        int acc_start = -1, acc_end = -1, if_done_at = -1, d_done_at = -1, dump_at = -1;
        int starve = 0, halt_t;
        logic acc_is_d = 1'b0, acc_wr = 1'b0, d_is_load = 1'b0, halt_lat = 1'b0;
        logic [15:0] acc_addr = '0, acc_wdata = '0, pend_if = '0, pend_d = '0;
        logic [15:0] exp_if_rdata = '0, exp_d_rdata = '0;
        bd_init = 1'b1;
        step();
        bd_init = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = pat(16'(i));
        halt_t = $urandom_range(1500, 2500);
        for (int t = 0; t < 3000; t++) begin
            logic en, e_if_done, e_d_done, if_el, d_el, g_if, g_d, sif, sd;
            logic [34:0] e_bus;
            logic [35:0] e_resp;
            halt = (t == halt_t);
            @(negedge clk);
            en = (t >= acc_start) && (t <= acc_end);
            e_if_done = (t == if_done_at);
            e_d_done = (t == d_done_at);
            if (e_if_done) exp_if_rdata = pend_if;
            if (e_d_done && d_is_load) exp_d_rdata = pend_d;
            e_bus = {en, en && acc_is_d && acc_wr && (t == acc_end),
                     en ? acc_addr : 16'h0000, (en && acc_is_d) ? acc_wdata : 16'h0000,
                     logic'(t == dump_at)};
            e_resp = {e_if_done, if_req & ~e_if_done, exp_if_rdata,
                      e_d_done, d_req & ~e_d_done, exp_d_rdata};
            checks++;
            if ({mem_enable, mem_wr, mem_addr, mem_data_in, mem_createdump} !== e_bus) begin
                errors++;
                $display("FAIL rand_bus t%0d: got %h expected %h", t,
                         {mem_enable, mem_wr, mem_addr, mem_data_in, mem_createdump}, e_bus);
            end
            checks++;
            if ({if_done, if_stall, if_rdata, d_done, d_stall, d_rdata} !== e_resp) begin
                errors++;
                $display("FAIL rand_resp t%0d: got %h expected %h", t,
                         {if_done, if_stall, if_rdata, d_done, d_stall, d_rdata}, e_resp);
            end
            if (t > acc_end && dump_at < 0) begin
                if (halt_lat) begin
                    dump_at = t + 1;
                end else begin
                    if_el = if_req && !e_if_done;
                    d_el = d_req && !e_d_done;
                    g_if = if_el && (!d_el || starve == SMAX);
                    g_d = d_el && !g_if;
                    if (g_d && if_el && starve < 3) starve++;
                    if (g_if) starve = 0;
                    if (g_if || g_d) begin
                        acc_start = t + 1;
                        acc_end = t + LAT;
                        acc_is_d = g_d;
                    end
                    if (g_if) begin
                        acc_addr = if_addr;
                        acc_wr = 1'b0;
                        if_done_at = t + LAT + 1;
                        pend_if = ref_mem[if_addr[3:0]];
                    end
                    if (g_d) begin
                        acc_addr = d_addr;
                        acc_wr = d_wr;
                        acc_wdata = d_wdata;
                        d_done_at = t + LAT + 1;
                        d_is_load = !d_wr;
                        if (d_wr) ref_mem[d_addr[3:0]] = d_wdata;
                        else pend_d = ref_mem[d_addr[3:0]];
                    end
                end
            end
            if (halt) halt_lat = 1'b1;
            sif = if_done;
            sd = d_done;
            step();
            if (if_req && sif) begin
                if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = 16'($urandom_range(0, 15));
            end
            if (d_req && sd) begin
                d_req = 1'b0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
        end
        if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_halt();
        test_reset_mid_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
